keypad_scan_encoder: RTL and testbench

//   Scans a 4x4 matrix keypad, debounces it and encodes one key into the processor's
//   key_value/key_valid input pair. key_valid is a level that stays high while a

---
 rtl/keypad_scan_encoder.sv | 178 +++++++++++++++++
 tb/tb_keypad_scan_encoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: scans a 4x4 keypad column by column, debounces whole scans and
// encodes one key as key_value/key_valid/key_pulse. Define KEYPAD_AUTOREPEAT_EN for autorepeat.
module keypad_scan_encoder #(
  parameter int SCAN_TICKS     = 10000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 50
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_pulse
);
  localparam int TW = $clog2(SCAN_TICKS);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] DB_DONE   = DW'(DEBOUNCE_SCANS);
  localparam logic [DW-1:0] DB_ONE    = DW'(1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  logic [3:0]    row_meta, row_sync;
  logic [TW-1:0] tick;
  logic [1:0]    acc_cnt, acc_cnt_next;  // row bits seen so far this scan, saturating at 2
  logic [3:0]    acc_code, acc_code_next;
  state_t        state, state_next;
  logic [DW-1:0] cnt, cnt_next, cnt_inc;
  logic [3:0]    cand, cand_next, key_value_next;
  logic          key_valid_next, key_pulse_next;
  logic          sample, scan_end, key_hit, key_match, rep_fire;
  logic [2:0]    row_ones;
  logic [1:0]    col_idx, row_idx;

  assign sample   = (tick == TICK_LAST);
  assign scan_end = sample && col[3];
  assign row_ones = {2'b0, row_sync[0]} + {2'b0, row_sync[1]}
                  + {2'b0, row_sync[2]} + {2'b0, row_sync[3]};
  assign cnt_inc  = (cnt == DB_DONE) ? cnt : cnt + 1'b1;

  always_comb begin
    unique case (col)
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    if (row_sync[0])      row_idx = 2'd0;
    else if (row_sync[1]) row_idx = 2'd1;
    else if (row_sync[2]) row_idx = 2'd2;
    else                  row_idx = 2'd3;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_cnt_next  = acc_cnt;
    acc_code_next = acc_code;
    if (row_ones != 3'd0) begin
      if (acc_cnt == 2'd0 && row_ones == 3'd1) begin
        acc_cnt_next  = 2'd1;
        acc_code_next = {row_idx, col_idx};
      end else begin
        acc_cnt_next  = 2'd2;
      end
    end
  end

  assign key_hit   = scan_end && (acc_cnt_next == 2'd1);
  assign key_match = key_hit && (acc_code_next == cand);

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      row_meta <= '0;
      row_sync <= '0;
      tick     <= '0;
      col      <= 4'b0001;
      acc_cnt  <= '0;
      acc_code <= '0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      if (sample) begin
        tick     <= '0;
        col      <= {col[2:0], col[3]};
        acc_cnt  <= scan_end ? 2'd0 : acc_cnt_next;
        acc_code <= acc_code_next;
      end else begin
        tick     <= tick + 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    cand_next      = cand;
    key_value_next = key_value;
    key_valid_next = key_valid;
    key_pulse_next = 1'b0;
    if (scan_end) begin
      unique case (state)
        IDLE: if (key_hit) begin
          cand_next  = acc_code_next;
          cnt_next   = DB_ONE;
          state_next = PRESS_DB;
        end
        PRESS_DB: if (key_match) begin
          cnt_next = cnt_inc;
          if (cnt_inc == DB_DONE) begin
            key_value_next = cand;
            key_valid_next = 1'b1;
            key_pulse_next = 1'b1;
            state_next     = HELD;
          end
        end else begin
          state_next = IDLE;
        end
        HELD: if (!key_match) begin
          cnt_next   = DB_ONE;
          state_next = REL_DB;
        end
        REL_DB: if (key_match) begin
          state_next = HELD;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == DB_DONE) begin
            key_valid_next = 1'b0;
            state_next     = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_value <= '0;
      key_valid <= 1'b0;
      key_pulse <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cand      <= cand_next;
      key_value <= key_value_next;
      key_valid <= key_valid_next;
      key_pulse <= key_pulse_next | rep_fire;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_DONE = RW'(REPEAT_SCANS);
  logic [RW-1:0] rep_cnt, rep_inc;

  assign rep_inc  = (rep_cnt == REP_DONE) ? rep_cnt : rep_cnt + 1'b1;
  assign rep_fire = scan_end && (state == HELD) && key_match && (rep_inc == REP_DONE);

  // Cleared on any scan that is not a held match, so entering HELD always starts from zero.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      rep_cnt <= '0;
    end else if (scan_end) begin
      if (state != HELD || !key_match || rep_fire) rep_cnt <= '0;
      else                                         rep_cnt <= rep_inc;
    end
  end
`else
  // Folds to constant zero; REPEAT_SCANS only has meaning with autorepeat built in.
  assign rep_fire = 1'b0 & (REPEAT_SCANS == 0);
`endif

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb_keypad_scan_encoder: directed plus random keypad stimulus, checked per full scan
// against a scan-level reference model of debounce, release and autorepeat rules.
module tb_keypad_scan_encoder;
  localparam int ST   = 4;
  localparam int DB   = 3;
  localparam int RP   = 5;
  localparam int SCAN = 4 * ST;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_p = 1'b1;
  logic [3:0]  row, col, key_value;
  logic        key_valid, key_pulse;
  logic [15:0] pressed = '0;  // bit r*4+c set when key (r,c) is held down

  int n_checks = 0;
  int n_fails  = 0;

  // Scan-level reference model
  bit m_valid, m_pending, m_pulse;
  int m_value, m_cand, m_streak, m_rel, m_rep;

  always #5 clk = ~clk;

  always_comb begin
    row = '0;
    for (int r = 0; r < 4; r++) row[r] = |(pressed[r*4 +: 4] & col);
  end

  keypad_scan_encoder #(
    .SCAN_TICKS    (ST),
    .DEBOUNCE_SCANS(DB),
    .REPEAT_SCANS  (RP)
  ) dut (
    .clk      (clk),
    .reset_p  (reset_p),
    .row      (row),
    .col      (col),
    .key_value(key_value),
    .key_valid(key_valid),
    .key_pulse(key_pulse)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int scan_result(input logic [15:0] keys);
    if ($countones(keys) != 1) return -1;
    for (int i = 0; i < 16; i++) if (keys[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pending = 0; m_pulse = 0;
    m_value = 0; m_cand = 0; m_streak = 0; m_rel = 0; m_rep = 0;
  endtask

  task automatic model_scan(input int res);
    m_pulse = 0;
    if (!m_valid) begin
      if (m_pending && res == m_cand) begin
        m_streak++;
        if (m_streak == DB) begin
          m_valid = 1; m_value = m_cand; m_pulse = 1;
          m_pending = 0; m_rel = 0; m_rep = 0;
        end
      end else if (m_pending) begin
        m_pending = 0;
      end else if (res >= 0) begin
        m_pending = 1; m_cand = res; m_streak = 1;
      end
    end else if (res == m_cand) begin
      if (m_rel > 0) begin
        m_rel = 0; m_rep = 0;
      end else if (AUTOREP) begin
        m_rep++;
        if (m_rep == RP) begin
          m_pulse = 1; m_rep = 0;
        end
      end
    end else begin
      m_rel++;
      if (m_rel == DB) begin
        m_valid = 0; m_rel = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_p = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("rst_pulse", key_pulse, 16'd0);
    end
    check("rst_col", col, 16'b0001);
    check("rst_value", key_value, 16'd0);
    check("rst_valid", key_valid, 16'd0);
    model_reset();
    reset_p = 1'b0;
  endtask

  task automatic run_scan(input logic [15:0] keys, input bit chk_col, input string tag);
    int pulses;
    pulses = 0;
    pressed = keys;
    for (int i = 1; i <= SCAN; i++) begin
      @(posedge clk); @(negedge clk);
      if (key_pulse === 1'b1) pulses++;
      if (chk_col) check({tag, "_col"}, col, 16'(4'b0001 << ((i / ST) % 4)));
    end
    model_scan(scan_result(keys));
    check({tag, "_pulses"}, 16'(pulses), 16'(m_pulse));
    check({tag, "_valid"}, 16'(key_valid), 16'(m_valid));
    check({tag, "_value"}, 16'(key_value), 16'(m_value));
  endtask

  localparam logic [15:0] K9   = 16'h1 << 9;                 // (2,1)
  localparam logic [15:0] KF   = 16'h1 << 15;                // (3,3)
  localparam logic [15:0] KMUL = (16'h1 << 0) | (16'h1 << 7); // (0,0)+(1,3)

  initial begin
    logic [15:0] keys;
    int sel;
    model_reset();

    // Reset values and column rotation with no keys
    do_reset();
    run_scan('0, 1'b1, "idle");

    // Steady press of (2,1), accepted at the 3rd scan, then held
    for (int s = 0; s < 5; s++) run_scan(K9, 1'b0, "press9");
    check("press9_final_value", key_value, 16'h9);
    // Release: valid holds for two scans and drops at the third
    for (int s = 0; s < 3; s++) run_scan('0, 1'b0, "release9");
    check("release9_valid_low", key_valid, 16'd0);
    check("release9_value_kept", key_value, 16'h9);

    // Re-accept, then a one-scan release glitch
    for (int s = 0; s < 4; s++) run_scan(K9, 1'b0, "repress9");
    run_scan('0, 1'b0, "glitch");
    for (int s = 0; s < 3; s++) run_scan(K9, 1'b0, "glitch_back");
    for (int s = 0; s < 3; s++) run_scan('0, 1'b0, "release_b");

    // One-scan tap and ghosting pattern: neither may be accepted
    run_scan(K9, 1'b0, "tap");
    for (int s = 0; s < 2; s++) run_scan('0, 1'b0, "tap_rel");
    for (int s = 0; s < 4; s++) run_scan(KMUL, 1'b0, "multi");
    run_scan('0, 1'b0, "multi_rel");

    // Reset during press debounce
    for (int s = 0; s < 2; s++) run_scan(K9, 1'b0, "pre_rst");
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      check("mid_pulse", key_pulse, 16'd0);
    end
    do_reset();
    for (int s = 0; s < 3; s++) run_scan(K9, 1'b0, "post_rst");
    for (int s = 0; s < 3; s++) run_scan('0, 1'b0, "post_rst_rel");

    // Long hold of (3,3): repeats every RP scans only when autorepeat is built in
    for (int s = 0; s < 3 + 3 * RP; s++) run_scan(KF, 1'b0, "holdF");
    check("holdF_value", key_value, 16'hF);
    for (int s = 0; s < 3; s++) run_scan('0, 1'b0, "holdF_rel");

    // Random scan sequence
    keys = '0;
    for (int s = 0; s < 150; s++) begin
      sel = $urandom_range(0, 99);
      if (sel < 45)      keys = keys;
      else if (sel < 65) keys = '0;
      else if (sel < 88) keys = 16'h1 << $urandom_range(0, 15);
      else               keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      run_scan(keys, 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
